// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the seven-segment scan driver.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_A   = 7'h08;
  localparam logic [6:0] SEG_B   = 7'h03;  // lowercase b
  localparam logic [6:0] SEG_C   = 7'h46;
  localparam logic [6:0] SEG_D   = 7'h21;  // lowercase d
  localparam logic [6:0] SEG_E   = 7'h06;
  localparam logic [6:0] SEG_F   = 7'h0E;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } scan_state_t;

endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational hex nibble to active-low seven-segment pattern.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Map each hex value to its display glyph
  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: four-digit multiplexed seven-segment driver.
// slow_clk is sampled as data; each synchronised rising edge advances the
// scan by one digit, with an optional all-off gap of BLANK_CYCLES.
// The display value is latched once per frame (on the 3 -> 0 wrap).
// Optional build macro: LEADING_ZERO_BLANK_EN (suppress leading zero digits).
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic        fast_clk,
  input  logic        rst,
  input  logic        slow_clk,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam int CNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (BLANK_CYCLES > 1) ? CNT_W'(BLANK_CYCLES - 1) : '0;

  logic             s1, s2, s3;
  logic             tick;
  scan_state_t      state, state_next;
  logic [IDX_W-1:0] idx, idx_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             wrap;
  logic [15:0]      val_q, val_next;
  logic [3:0]       dp_q, dp_next;
  logic [3:0]       nibble;
  logic [6:0]       dec_seg;
  logic             lz_blank;
  logic [3:0]       an_next;
  logic [6:0]       seg_next;
  logic             dp_n_next;

  // One-cycle pulse per synchronised rising edge of slow_clk
  assign tick = s2 & ~s3;

  // Scan sequencing: advance on tick, hold off for the blanking gap
  always_comb begin
    state_next = state;
    idx_next   = idx;
    cnt_next   = cnt;
    wrap       = 1'b0;
    case (state)
      SHOW: begin
        if (tick) begin
          idx_next = idx + 1'b1;
          wrap     = (idx == IDX_LAST);
          if (BLANK_CYCLES > 0) begin
            state_next = BLANK;
            cnt_next   = '0;
          end
        end
      end
      BLANK: begin
        // Ticks seen here are intentionally dropped.
        if (cnt == CNT_LAST) begin
          state_next = SHOW;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = SHOW;
    endcase
  end

  // Outputs are registered, so decode from the post-edge view of the data.
  assign val_next = wrap ? value : val_q;
  assign dp_next  = wrap ? dp    : dp_q;
  assign nibble   = val_next[{idx_next, 2'b00} +: 4];

  hex_to_seg7 u_dec (
    .nibble (nibble),
    .seg    (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // Digit k (k >= 1) is dark when it and every higher nibble are zero
  always_comb begin
    lz_blank = 1'b0;
    case (idx_next)
      2'd3:    lz_blank = (val_next[15:12] == 4'h0);
      2'd2:    lz_blank = (val_next[15:8]  == 8'h00);
      2'd1:    lz_blank = (val_next[15:4]  == 12'h000);
      default: lz_blank = 1'b0;
    endcase
  end
`else
  assign lz_blank = 1'b0;
`endif

  // Drive the selected anode, or everything off during a gap / blanked slot
  always_comb begin
    an_next   = 4'b1111;
    seg_next  = SEG_OFF;
    dp_n_next = 1'b1;
    if ((state_next == SHOW) && !lz_blank) begin
      an_next[idx_next] = 1'b0;
      seg_next          = dec_seg;
      dp_n_next         = ~dp_next[idx_next];
    end
  end

  // State, synchroniser, frame latch and output registers
  always_ff @(posedge fast_clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      state <= SHOW;
      idx   <= '0;
      cnt   <= '0;
      val_q <= '0;
      dp_q  <= '0;
      an    <= 4'b1111;
      seg   <= SEG_OFF;
      dp_n  <= 1'b1;
    end else begin
      s1    <= slow_clk;
      s2    <= s1;
      s3    <= s2;
      state <= state_next;
      idx   <= idx_next;
      cnt   <= cnt_next;
      val_q <= val_next;
      dp_q  <= dp_next;
      an    <= an_next;
      seg   <= seg_next;
      dp_n  <= dp_n_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux: directed self-checking bench for seg7_scan_mux
// with BLANK_CYCLES = 2.
module tb_seg7_scan_mux;

  logic        fast_clk;
  logic        rst;
  logic        slow_clk;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;

  int total = 0;
  int bad   = 0;

  seg7_scan_mux #(.BLANK_CYCLES(2)) dut (
    .fast_clk (fast_clk),
    .rst      (rst),
    .slow_clk (slow_clk),
    .value    (value),
    .dp       (dp),
    .an       (an),
    .seg      (seg),
    .dp_n     (dp_n)
  );

  initial begin
    fast_clk = 1'b0;
    forever #5 fast_clk = ~fast_clk;
  end

  task automatic step();
    @(posedge fast_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One slow_clk pulse: rise sampled at edge N, new digit after N+4
  task automatic scan_tick(input logic [3:0] an_prev, input logic [3:0] an_exp,
                           input logic [6:0] seg_exp, input logic dpn_exp,
                           input string tag);
    slow_clk = 1'b1;
    step();                                   // edge N
    chk({tag, "_an_N"}, an, an_prev);
    step();                                   // edge N+1
    chk({tag, "_an_N1"}, an, an_prev);
    step();                                   // edge N+2: gap begins
    chk({tag, "_an_gap1"}, an, 4'hF);
    chk({tag, "_seg_gap1"}, seg, 7'h7F);
    step();                                   // edge N+3
    chk({tag, "_an_gap2"}, an, 4'hF);
    step();                                   // edge N+4: next digit
    chk({tag, "_an"}, an, an_exp);
    chk({tag, "_seg"}, seg, seg_exp);
    chk({tag, "_dpn"}, dp_n, dpn_exp);
    slow_clk = 1'b0;
    repeat (5) step();
    chk({tag, "_fall_an"}, an, an_exp);
    repeat (10) step();
  endtask

  initial begin
    rst      = 1'b1;
    slow_clk = 1'b0;
    value    = 16'h0000;
    dp       = 4'b0000;

    // Reset held for three cycles
    repeat (3) step();
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dpn", dp_n, 1'b1);
    rst = 1'b0;
    step();
    chk("post_rst_an", an, 4'hE);
    chk("post_rst_seg", seg, 7'h40);
    chk("post_rst_dpn", dp_n, 1'b1);

    // Prime the frame latch with 1A3F (previous frame still shows zeros)
    value = 16'h1A3F;
    scan_tick(4'hE, 4'hD, 7'h40, 1'b1, "p1");
    scan_tick(4'hD, 4'hB, 7'h40, 1'b1, "p2");
    scan_tick(4'hB, 4'h7, 7'h40, 1'b1, "p3");
    scan_tick(4'h7, 4'hE, 7'h0E, 1'b1, "p0_F");

    // Full scan of 1A3F; queue 1234 for the following frame
    value = 16'h1234;
    scan_tick(4'hE, 4'hD, 7'h30, 1'b1, "s1_3");
    scan_tick(4'hD, 4'hB, 7'h08, 1'b1, "s2_A");
    scan_tick(4'hB, 4'h7, 7'h79, 1'b1, "s3_1");
    scan_tick(4'h7, 4'hE, 7'h19, 1'b1, "f0_4");

    // Change value while digit 1 is lit: rest of frame must not tear
    scan_tick(4'hE, 4'hD, 7'h30, 1'b1, "f1_3");
    value = 16'hABCD;
    scan_tick(4'hD, 4'hB, 7'h24, 1'b1, "f2_2");
    scan_tick(4'hB, 4'h7, 7'h79, 1'b1, "f3_1");
    scan_tick(4'h7, 4'hE, 7'h21, 1'b1, "g0_d");
    scan_tick(4'hE, 4'hD, 7'h46, 1'b1, "g1_C");
    scan_tick(4'hD, 4'hB, 7'h03, 1'b1, "g2_b");
    value = 16'h0005;
    dp    = 4'b1000;
    scan_tick(4'hB, 4'h7, 7'h08, 1'b1, "g3_A");

    // Leading zeros with the top decimal point enabled
    scan_tick(4'h7, 4'hE, 7'h12, 1'b1, "z0_5");
`ifdef LEADING_ZERO_BLANK_EN
    scan_tick(4'hE, 4'hF, 7'h7F, 1'b1, "z1_off");
    scan_tick(4'hF, 4'hF, 7'h7F, 1'b1, "z2_off");
    scan_tick(4'hF, 4'hF, 7'h7F, 1'b1, "z3_off");
`else
    scan_tick(4'hE, 4'hD, 7'h40, 1'b1, "z1_0");
    scan_tick(4'hD, 4'hB, 7'h40, 1'b1, "z2_0");
    scan_tick(4'hB, 4'h7, 7'h40, 1'b0, "z3_0dp");
`endif

    // Second rise lands while the gap is running and must be dropped
    slow_clk = 1'b1;
    step();                                   // edge N
    slow_clk = 1'b0;
    step();                                   // edge N+1
    slow_clk = 1'b1;
    step();                                   // edge N+2
    chk("drop_gap1", an, 4'hF);
    step();                                   // edge N+3
    chk("drop_gap2", an, 4'hF);
    step();                                   // edge N+4
    chk("drop_an", an, 4'hE);
    chk("drop_seg", seg, 7'h12);
    repeat (6) step();
    chk("drop_hold_an", an, 4'hE);
    slow_clk = 1'b0;
    repeat (6) step();
    chk("drop_fall_an", an, 4'hE);

    // Reset asserted in the middle of a gap
    slow_clk = 1'b1;
    repeat (3) step();                        // edges N..N+2
    chk("mid_gap_an", an, 4'hF);
    rst      = 1'b1;
    slow_clk = 1'b0;
    step();
    chk("mid_rst_an", an, 4'hF);
    chk("mid_rst_seg", seg, 7'h7F);
    chk("mid_rst_dpn", dp_n, 1'b1);
    rst = 1'b0;
    step();
    chk("mid_rel_an", an, 4'hE);
    chk("mid_rel_seg", seg, 7'h40);
    repeat (4) step();
    chk("mid_hold_an", an, 4'hE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
